// File: rtl/neuron_accumulator.sv
// Streams x/w pairs into a signed multiply-accumulate seeded with the bias, then requantizes
// the sum with an arithmetic shift and saturation onto a valid/ready result port.
module neuron_accumulator #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAC_BITS  = 4,
  parameter int LEN_WIDTH  = 8,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [DATA_WIDTH-1:0] bias,
  output logic                  busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] w,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sat
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_QUANT = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  localparam logic signed [ACC_WIDTH-1:0] Q_MAX_C =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] Q_MIN_C =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] OUT_MAX_C = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] OUT_MIN_C = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [LEN_WIDTH-1:0]  CNT_ONE_C = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0]  CNT_ZERO_C = {LEN_WIDTH{1'b0}};

  state_t                         state_r;
  state_t                         state_nxt_s;
  logic signed [ACC_WIDTH-1:0]    acc_r;
  logic        [LEN_WIDTH-1:0]    cnt_r;
  logic        [DATA_WIDTH-1:0]   out_data_r;
  logic                           out_sat_r;
  logic                           out_valid_r;
  logic signed [2*DATA_WIDTH-1:0] prod_s;
  logic signed [ACC_WIDTH-1:0]    prod_ext_s;
  logic signed [ACC_WIDTH-1:0]    bias_ext_s;
  logic signed [ACC_WIDTH-1:0]    q_s;
  logic                           accept_s;
  logic                           handshake_s;

  assign prod_s      = $signed(x) * $signed(w);
  assign prod_ext_s  = {{(ACC_WIDTH-2*DATA_WIDTH){prod_s[2*DATA_WIDTH-1]}}, prod_s};
  assign bias_ext_s  = {{(ACC_WIDTH-DATA_WIDTH-FRAC_BITS){bias[DATA_WIDTH-1]}}, bias,
                        {FRAC_BITS{1'b0}}};
  assign q_s         = acc_r >>> FRAC_BITS;
  assign accept_s    = in_valid && (state_r == ST_ACCUM);
  assign handshake_s = out_valid_r && out_ready;

  assign busy      = (state_r != ST_IDLE);
  assign in_ready  = (state_r == ST_ACCUM);
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_sat   = out_sat_r;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = (len != CNT_ZERO_C) ? ST_ACCUM : ST_QUANT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (accept_s && (cnt_r == CNT_ONE_C)) begin
          state_nxt_s = ST_QUANT;
        end else begin
          state_nxt_s = ST_ACCUM;
        end
      end
      ST_QUANT: state_nxt_s = ST_OUT;
      ST_OUT: begin
        if (handshake_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_OUT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Accumulator, term counter and requantized result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r       <= {ACC_WIDTH{1'b0}};
      cnt_r       <= CNT_ZERO_C;
      out_data_r  <= {DATA_WIDTH{1'b0}};
      out_sat_r   <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            acc_r <= bias_ext_s;
            cnt_r <= len;
          end
        end
        ST_ACCUM: begin
          if (accept_s) begin
            acc_r <= acc_r + prod_ext_s;
            cnt_r <= cnt_r - CNT_ONE_C;
          end
        end
        ST_QUANT: begin
          if (q_s > Q_MAX_C) begin
            out_data_r <= OUT_MAX_C;
            out_sat_r  <= 1'b1;
          end else if (q_s < Q_MIN_C) begin
            out_data_r <= OUT_MIN_C;
            out_sat_r  <= 1'b1;
          end else begin
            out_data_r <= q_s[DATA_WIDTH-1:0];
            out_sat_r  <= 1'b0;
          end
        end
        ST_OUT: begin
          // valid rises one cycle into OUT, giving the two-edge result latency
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Randomized self-checking bench for neuron_accumulator against an integer reference model
// of the biased dot product, floor requantization and saturation.
module tb_neuron_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] len;
  logic [7:0] bias;
  logic       busy;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] x;
  logic [7:0] w;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_sat;

  int checks   = 0;
  int failures = 0;
  int hs_seen  = 0;
  int sums_run = 0;
  int xs[256];
  int ws[256];

  neuron_accumulator #(
    .DATA_WIDTH(8), .FRAC_BITS(4), .LEN_WIDTH(8), .ACC_WIDTH(24)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .bias(bias), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .x(x), .w(w),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  // Count output handshakes to detect lost or duplicated results
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) hs_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: real-valued bias + sum(x*w) in 1/256 units, floored to 1/16 and clipped
  task automatic model(input int b, input int n, output int q, output int sat);
    int sum;
    sum = b * 16;
    for (int i = 0; i < n; i++) sum += xs[i] * ws[i];
    q = sum >>> 4;
    sat = 0;
    if (q > 127) begin
      q = 127;
      sat = 1;
    end else if (q < -128) begin
      q = -128;
      sat = 1;
    end
  endtask

  task automatic run_sum(input int b, input int n, input int max_gap, input int hold,
                         input bit keep_ready);
    int q;
    int sat;
    int lat;
    int gap;
    logic [7:0] held;
    model(b, n, q, sat);
    lat = 0;
    while (busy && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    check("idle_before_start", busy, 0);
    start = 1'b1;
    len = 8'(n);
    bias = 8'(b);
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    len = 8'($urandom);
    bias = 8'($urandom);
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(0, max_gap);
      repeat (gap) begin
        in_valid = 1'b0;
        x = 8'($urandom);
        w = 8'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b1;
      x = 8'(xs[i]);
      w = 8'(ws[i]);
      lat = 0;
      while (!in_ready && lat < 50) begin
        @(negedge clk);
        lat++;
      end
      check("in_ready_accum", in_ready, 1);
      @(negedge clk);
    end
    in_valid = 1'($urandom_range(0, 1));
    x = 8'($urandom);
    w = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      check("in_ready_low", in_ready, 0);
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 2);
    check("out_data", out_data, q & 255);
    check("out_sat", out_sat, sat);
    if (hold > 0) begin
      out_ready = 1'b0;
      held = out_data;
      repeat (hold) begin
        start = 1'($urandom_range(0, 1));
        len = 8'($urandom);
        in_valid = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, held);
        check("hold_in_ready", in_ready, 0);
        check("hold_busy", busy, 1);
      end
      start = 1'b0;
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    sums_run++;
    check("valid_drop", out_valid, 0);
    check("idle_after", busy, 0);
    check("data_kept", out_data, q & 255);
    out_ready = keep_ready;
  endtask

  task automatic rand_operands(input int n);
    for (int i = 0; i < n; i++) begin
      xs[i] = $urandom_range(0, 255) - 128;
      ws[i] = $urandom_range(0, 255) - 128;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    len = 8'd0;
    bias = 8'd0;
    in_valid = 1'b0;
    x = 8'd0;
    w = 8'd0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic sum: 1.0 + 2*1 + 1*(-1) = 2.0
    xs[0] = 32; ws[0] = 16; xs[1] = 16; ws[1] = -16;
    run_sum(16, 2, 0, 0, 1'b0);
    check("basic_value", out_data, 32);

    // Saturation both ways, floor toward -inf, empty sum
    xs[0] = 127; ws[0] = 127;
    run_sum(0, 1, 0, 0, 1'b0);
    check("pos_sat_value", out_data, 127);
    xs[0] = 127; ws[0] = -128;
    run_sum(0, 1, 0, 0, 1'b0);
    check("neg_sat_value", out_data, 128);
    xs[0] = 1; ws[0] = -1;
    run_sum(0, 1, 0, 0, 1'b0);
    check("floor_value", out_data, 255);
    run_sum(-5, 0, 0, 0, 1'b0);
    check("len0_value", out_data, 251);

    // Backpressure on input and output
    rand_operands(4);
    run_sum($urandom_range(0, 255) - 128, 4, 3, 5, 1'b0);

    // Reset mid-sum abandons the work in flight
    xs[0] = 100; ws[0] = 100;
    run_sum(0, 1, 0, 0, 1'b0);
    start = 1'b1;
    len = 8'd4;
    bias = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) begin
      in_valid = 1'b1;
      x = 8'($urandom);
      w = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_sat", out_sat, 0);
    @(negedge clk);
    xs[0] = 32; ws[0] = 16; xs[1] = 16; ws[1] = -16;
    run_sum(16, 2, 0, 0, 1'b0);
    check("post_reset_value", out_data, 32);

    // Back-to-back sums with out_ready tied high
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int n;
      n = $urandom_range(1, 6);
      rand_operands(n);
      run_sum($urandom_range(0, 255) - 128, n, 0, 0, 1'b1);
    end
    out_ready = 1'b0;

    // Randomized mix including a maximum-length sum
    rand_operands(255);
    run_sum($urandom_range(0, 255) - 128, 255, 1, 2, 1'b0);
    for (int k = 0; k < 25; k++) begin
      int n;
      n = $urandom_range(0, 10);
      rand_operands(n);
      run_sum($urandom_range(0, 255) - 128, n, $urandom_range(0, 2), $urandom_range(0, 3),
              1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("handshake_count", hs_seen, sums_run);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
